// File: rtl/inst_fetch_responder.sv
// Fetch responder: direct-mapped instruction cache with one 32-bit word per line; misses fill byte-serially from memory.
// Latency: hit 1 cycle; miss = WAIT_GRANT cycles + 5 FILL cycles + 1 RESP cycle.
// Backpressure: rdy_in low freezes all state; new fetches are accepted only in IDLE, and _clear aborts any outstanding fetch.
module inst_fetch_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _fetch_en,
    input  logic [31:0] _pc,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_out,
    output logic [31:0] _inst_addr_out,
    output logic        _mem_req,
    input  logic        _mem_grant,
    output logic [31:0] _mem_addr,
    input  logic [7:0]  _mem_byte_in
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_GRANT,
        S_FILL,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           pc_q, pc_d;
    logic [23:0]           fill_q, fill_d;
    logic                  ready_q, ready_d;
    logic [31:0]           inst_q, inst_d;
    logic [31:0]           inst_addr_q, inst_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [LINES-1:0]      valid_q, valid_d;

    logic [TAG_BITS-1:0]   tag_mem_q  [LINES];
    logic [31:0]           data_mem_q [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [31:0]           fill_base;
    logic [31:0]           fill_word;
    logic                  wr_en;

    // Lookup for the incoming PC and line/base address of the fetch in flight.
    always_comb begin
        req_idx   = _pc[INDEX_BITS+1:2];
        req_tag   = _pc[31:INDEX_BITS+2];
        req_hit   = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
        fill_idx  = pc_q[INDEX_BITS+1:2];
        fill_tag  = pc_q[31:INDEX_BITS+2];
        fill_base = {pc_q[31:2], 2'b00};
        fill_word = {_mem_byte_in, fill_q};
    end

    // Next-state, fill sequencing and output register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        fill_d      = fill_q;
        ready_d     = 1'b0;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        valid_d     = valid_q;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (_fetch_en && !_clear) begin
                    pc_d = _pc;
                    if (req_hit) begin
                        ready_d     = 1'b1;
                        inst_d      = data_mem_q[req_idx];
                        inst_addr_d = _pc;
                    end else begin
                        state_d    = S_WAIT_GRANT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {_pc[31:2], 2'b00};
                    end
                end
            end
            S_WAIT_GRANT: begin
                if (_mem_grant) begin
                    state_d = S_FILL;
                    cnt_d   = 3'd0;
                end
            end
            S_FILL: begin
                // Byte arriving now belongs to the address presented last cycle.
                case (cnt_q)
                    3'd1:    fill_d[7:0]   = _mem_byte_in;
                    3'd2:    fill_d[15:8]  = _mem_byte_in;
                    3'd3:    fill_d[23:16] = _mem_byte_in;
                    default: fill_d        = fill_q;
                endcase
                if (cnt_q == 3'd4) begin
                    wr_en             = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    mem_req_d         = 1'b0;
                    state_d           = S_RESP;
                    ready_d           = 1'b1;
                    inst_d            = fill_word;
                    inst_addr_d       = pc_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < 3'd3) begin
                        mem_addr_d = fill_base + 32'(cnt_q) + 32'd1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush: a just-completed fill still lands in the cache, but nothing is reported.
        if (_clear) begin
            state_d     = S_IDLE;
            mem_req_d   = 1'b0;
            ready_d     = 1'b0;
            inst_d      = inst_q;
            inst_addr_d = inst_addr_q;
        end
    end

    // Control and output registers; rdy_in low holds everything in place.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            pc_q        <= 32'd0;
            fill_q      <= 24'd0;
            ready_q     <= 1'b0;
            inst_q      <= 32'd0;
            inst_addr_q <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            valid_q     <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            fill_q      <= fill_d;
            ready_q     <= ready_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every hit.
    always_ff @(posedge clk_in) begin
        if (rdy_in && wr_en) begin
            tag_mem_q[fill_idx]  <= fill_tag;
            data_mem_q[fill_idx] <= fill_word;
        end
    end

    assign _inst_ready_out = ready_q;
    assign _inst_out       = inst_q;
    assign _inst_addr_out  = inst_addr_q;
    assign _mem_req        = mem_req_q;
    assign _mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder against a behavioural cache/memory model.
// Latency: checks hit (1 cycle) and miss (grant wait + fill + response) timing cycle by cycle.
// Backpressure: exercises grant stalls, rdy_in freezes, _clear flushes and reset mid-fill.
module tb_inst_fetch_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _fetch_en;
    logic [31:0] _pc;
    logic        _inst_ready_out;
    logic [31:0] _inst_out;
    logic [31:0] _inst_addr_out;
    logic        _mem_req;
    logic        _mem_grant;
    logic [31:0] _mem_addr;
    logic [7:0]  _mem_byte_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference cache: 16 lines indexed by pc[5:2], tag pc[31:6].
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];

    logic [31:0] mem_addr_lat = 32'd0;
    bit          mem_rdy_lat  = 1'b0;

    inst_fetch_responder #(.INDEX_BITS(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._fetch_en      (_fetch_en),
        ._pc            (_pc),
        ._inst_ready_out(_inst_ready_out),
        ._inst_out      (_inst_out),
        ._inst_addr_out (_inst_addr_out),
        ._mem_req       (_mem_req),
        ._mem_grant     (_mem_grant),
        ._mem_addr      (_mem_addr),
        ._mem_byte_in   (_mem_byte_in)
    );

    always #5 clk_in = ~clk_in;

    // Memory contents: fixed bytes at 0..3, a hash of the address elsewhere.
    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    // Synchronous byte memory sharing the global ready: address taken at an
    // enabled edge, data visible through the following cycle.
    always @(posedge clk_in) begin
        mem_addr_lat = _mem_addr;
        mem_rdy_lat  = rdy_in;
    end
    always @(negedge clk_in) begin
        if (mem_rdy_lat) _mem_byte_in = mb(mem_addr_lat);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] base);
        return {mb(base + 32'd3), mb(base + 32'd2), mb(base + 32'd1), mb(base)};
    endfunction

    // One fetch from IDLE, called right after a negedge. clear_c >= 0 asserts
    // _clear during FILL cycle c; freeze_len > 0 drops rdy_in during FILL c=1.
    task automatic do_fetch(input logic [31:0] pc, input int gwait,
                            input int freeze_len, input int clear_c);
        logic [31:0] base;
        int          idx;
        int          lat;
        bit          hit;
        base = {pc[31:2], 2'b00};
        idx  = int'(pc[5:2]);
        hit  = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        _pc = pc;
        _fetch_en = 1'b1;
        @(negedge clk_in);
        _fetch_en = 1'b0;
        lat = 1;
        if (hit) begin
            check("hit_ready", 32'(_inst_ready_out), 32'd1);
            check("hit_data", _inst_out, m_data[idx]);
            check("hit_addr", _inst_addr_out, pc);
            check("hit_no_req", 32'(_mem_req), 32'd0);
            @(negedge clk_in);
            check("hit_pulse_end", 32'(_inst_ready_out), 32'd0);
            return;
        end
        check("miss_req", 32'(_mem_req), 32'd1);
        check("miss_no_ready", 32'(_inst_ready_out), 32'd0);
        check("miss_addr", _mem_addr, base);
        repeat (gwait) begin
            @(negedge clk_in);
            lat++;
            check("wait_req", 32'(_mem_req), 32'd1);
            check("wait_addr", _mem_addr, base);
            check("wait_no_ready", 32'(_inst_ready_out), 32'd0);
        end
        _mem_grant = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk_in);
            lat++;
            if (c < 4) check("fill_addr", _mem_addr, base + 32'(c));
            check("fill_req", 32'(_mem_req), 32'd1);
            check("fill_no_ready", 32'(_inst_ready_out), 32'd0);
            if (c == 1 && freeze_len > 0) begin
                rdy_in = 1'b0;
                repeat (freeze_len) begin
                    @(negedge clk_in);
                    lat++;
                    check("freeze_addr", _mem_addr, base + 32'd1);
                    check("freeze_req", 32'(_mem_req), 32'd1);
                    check("freeze_no_ready", 32'(_inst_ready_out), 32'd0);
                end
                rdy_in = 1'b1;
            end
            if (c == clear_c) begin
                _clear = 1'b1;
                @(negedge clk_in);
                _clear = 1'b0;
                _mem_grant = 1'b0;
                check("clear_req", 32'(_mem_req), 32'd0);
                check("clear_no_ready", 32'(_inst_ready_out), 32'd0);
                @(negedge clk_in);
                check("clear_no_late_ready", 32'(_inst_ready_out), 32'd0);
                check("clear_req_stays_low", 32'(_mem_req), 32'd0);
                if (c == 4) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = pc[31:6];
                    m_data[idx]  = model_word(base);
                end
                return;
            end
        end
        @(negedge clk_in);
        lat++;
        check("resp_ready", 32'(_inst_ready_out), 32'd1);
        check("resp_data", _inst_out, model_word(base));
        check("resp_addr", _inst_addr_out, pc);
        check("resp_req_dropped", 32'(_mem_req), 32'd0);
        check("miss_latency", 32'(lat), 32'(gwait + 7 + freeze_len));
        _mem_grant = 1'b0;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = pc[31:6];
        m_data[idx]  = model_word(base);
        @(negedge clk_in);
        check("resp_single_pulse", 32'(_inst_ready_out), 32'd0);
    endtask

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        _clear     = 1'b0;
        _fetch_en  = 1'b0;
        _pc        = 32'd0;
        _mem_grant = 1'b0;
        _mem_byte_in = 8'd0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_ready", 32'(_inst_ready_out), 32'd0);
        check("rst_inst", _inst_out, 32'd0);
        check("rst_inst_addr", _inst_addr_out, 32'd0);
        check("rst_mem_req", 32'(_mem_req), 32'd0);
        check("rst_mem_addr", _mem_addr, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Cold miss at 0 with the fixed bytes, then a hit on the same word.
        do_fetch(32'h0000_0000, 0, 0, -1);
        check("first_word", _inst_out, 32'h0050_0013);
        do_fetch(32'h0000_0000, 0, 0, -1);

        // Back-to-back hits on two prefilled words.
        do_fetch(32'h0000_0004, 1, 0, -1);
        do_fetch(32'h0000_0008, 0, 0, -1);
        _pc = 32'h0000_0004;
        _fetch_en = 1'b1;
        @(negedge clk_in);
        check("b2b_ready0", 32'(_inst_ready_out), 32'd1);
        check("b2b_data0", _inst_out, m_data[1]);
        _pc = 32'h0000_0008;
        @(negedge clk_in);
        _fetch_en = 1'b0;
        check("b2b_ready1", 32'(_inst_ready_out), 32'd1);
        check("b2b_data1", _inst_out, m_data[2]);
        check("b2b_addr1", _inst_addr_out, 32'h0000_0008);
        check("b2b_no_req", 32'(_mem_req), 32'd0);
        @(negedge clk_in);
        check("b2b_end", 32'(_inst_ready_out), 32'd0);

        // Conflict eviction on index 0.
        do_fetch(32'h0000_0040, 0, 0, -1);
        do_fetch(32'h0000_0000, 2, 0, -1);
        do_fetch(32'h0000_0040, 0, 0, -1);

        // Flush mid-fill, then refetch from byte 0.
        do_fetch(32'h0000_0080, 0, 0, 2);
        do_fetch(32'h0000_0080, 0, 0, -1);

        // Freeze during FILL c=1.
        do_fetch(32'h0000_00C4, 0, 3, -1);

        // Long grant stall.
        do_fetch(32'h0000_0108, 10, 0, -1);

        // Fill completing together with a flush: written but not reported.
        do_fetch(32'h0000_020C, 0, 0, 4);
        do_fetch(32'h0000_020C, 0, 0, -1);

        // Request coincident with _clear is dropped.
        _pc = 32'h0000_0310;
        _fetch_en = 1'b1;
        _clear = 1'b1;
        @(negedge clk_in);
        _fetch_en = 1'b0;
        _clear = 1'b0;
        check("clr_fetch_no_req", 32'(_mem_req), 32'd0);
        check("clr_fetch_no_ready", 32'(_inst_ready_out), 32'd0);
        @(negedge clk_in);
        check("clr_fetch_still_idle", 32'(_mem_req), 32'd0);

        // Top-of-address-space word.
        do_fetch(32'hFFFF_FFFC, 1, 0, -1);

        // Reset in the middle of a fill invalidates everything.
        _pc = 32'h0000_0014;
        _fetch_en = 1'b1;
        @(negedge clk_in);
        _fetch_en = 1'b0;
        _mem_grant = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        _mem_grant = 1'b0;
        @(negedge clk_in);
        check("rst_fill_req", 32'(_mem_req), 32'd0);
        check("rst_fill_addr", _mem_addr, 32'd0);
        check("rst_fill_ready", 32'(_inst_ready_out), 32'd0);
        rst_in = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        @(negedge clk_in);
        do_fetch(32'h0000_0000, 0, 0, -1);

        // Randomized mix over a small address pool so hits and conflicts recur.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] pc;
            logic [25:0] tg;
            int          cl;
            int          fz;
            case ($urandom_range(0, 3))
                0:       tg = 26'd0;
                1:       tg = 26'd1;
                2:       tg = 26'd2;
                default: tg = 26'h3FF_FFFF;
            endcase
            pc = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            cl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            fz = (cl < 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_fetch(pc, int'($urandom_range(0, 3)), fz, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
